// File: rtl/ddr_rx_align_monitor.sv
// ---------------------------------------------------------------------------
// ddr_rx_align_monitor
//
// Purpose:
//   Rx-side companion to the PLL phase controller. Watches deserialized
//   training words from the SERDES/DDR input gearbox, hunts for the word
//   boundary after a datapath reset, barrel-shifts rx_data onto it and
//   reports sampling / word-alignment health back to the controller.
//
// Ports:
//   clk             in   core clock (same domain as the phase controller)
//   rst_n           in   asynchronous active-low reset
//   lock            in   PLL lock, synchronous to clk
//   reset_datapath  in   datapath reset from the controller, active high
//   stop            in   controller stop; freezes the block
//   rx_valid        in   rx_data qualifier
//   rx_data         in   raw DW-bit word from the gearbox
//   align_status    out  [0]=sample error, [1]=word-alignment error (1 = bad)
//   data_out        out  aligned word (1-cycle latency)
//   data_out_valid  out  qualifier for data_out
//   shift           out  current bit offset of the barrel shifter
//   aligned         out  high only while LOCKED
//   err_count       out  (ALIGN_ERR_CNT_EN only) saturating count of
//                        mismatched valid words seen while LOCKED
//
// Build option:
//   ALIGN_ERR_CNT_EN  - when defined, adds the err_count output and counter.
// ---------------------------------------------------------------------------
module ddr_rx_align_monitor #(
    parameter int              DW          = 8,
    parameter logic [DW-1:0]   PATTERN     = 8'h1F,
    parameter int              WIN         = 16,
    parameter int              CONFIRM_CNT = 4,
    parameter int              ERR_THR     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lock,
    input  logic                  reset_datapath,
    input  logic                  stop,
    input  logic                  rx_valid,
    input  logic [DW-1:0]         rx_data,
    output logic [1:0]            align_status,
    output logic [DW-1:0]         data_out,
    output logic                  data_out_valid,
    output logic [$clog2(DW)-1:0] shift,
    output logic                  aligned
`ifdef ALIGN_ERR_CNT_EN
    ,
    output logic [15:0]           err_count
`endif
);

    localparam int SW = $clog2(DW);
    localparam int CW = $clog2(CONFIRM_CNT + 1);
    localparam int EW = $clog2(ERR_THR + 1);
    localparam int WW = $clog2(WIN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        CONFIRM = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   shift_reg, shift_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [EW-1:0]   errcnt_reg, errcnt_next;
    logic [WW-1:0]   win_cnt_reg, win_cnt_next;
    logic            win_flag_reg, win_flag_next;
    logic [1:0]      status_reg, status_next;

    logic [DW-1:0]   prev_reg;
    logic [DW-1:0]   data_out_reg;
    logic            dov_reg;

    // stop masks the input stream entirely; every consumer below uses vld.
    logic            vld;
    assign vld = rx_valid && !stop;

    // -----------------------------------------------------------------------
    // Candidate words: every DW-bit window straddling the previous and the
    // current word. A boundary offset of k takes the top DW-k bits of prev
    // and the low k bits of rx_data.
    // -----------------------------------------------------------------------
    logic [2*DW-1:0] word_pair;
    logic [DW-1:0]   cand [DW];
    logic [DW-1:0]   match;
    logic            any_match;
    logic [SW-1:0]   hunt_shift;

    assign word_pair = {rx_data, prev_reg};

    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_cand
            assign cand[gi]  = word_pair[gi +: DW];
            assign match[gi] = (cand[gi] == PATTERN);
        end
    endgenerate

    assign any_match = |match;

    // Lowest matching offset; scanning downward lets the smallest k win.
    always_comb begin
        hunt_shift = '0;
        for (int k = DW - 1; k >= 0; k--) begin
            if (match[k]) begin
                hunt_shift = SW'(k);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            cnt_reg      <= '0;
            errcnt_reg   <= '0;
            win_cnt_reg  <= '0;
            win_flag_reg <= 1'b0;
            status_reg   <= 2'b11;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            cnt_reg      <= cnt_next;
            errcnt_reg   <= errcnt_next;
            win_cnt_reg  <= win_cnt_next;
            win_flag_reg <= win_flag_next;
            status_reg   <= status_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic: sampling window, alignment FSM, then overrides
    // (lock loss beats datapath reset; stop is already folded into vld).
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        cnt_next      = cnt_reg;
        errcnt_next   = errcnt_reg;
        win_cnt_next  = win_cnt_reg;
        win_flag_next = win_flag_reg;
        status_next   = status_reg;

        // Sampling check: a word with no matching rotation at all means the
        // bits themselves are being sampled wrongly, whatever the boundary.
        if (state_reg != IDLE && vld) begin
            if (win_cnt_reg == WW'(WIN - 1)) begin
                status_next[0] = win_flag_reg | ~any_match;
                win_cnt_next   = '0;
                win_flag_next  = 1'b0;
            end else begin
                win_cnt_next   = win_cnt_reg + 1'b1;
                win_flag_next  = win_flag_reg | ~any_match;
            end
        end

        unique case (state_reg)
            IDLE: begin
                if (!stop && lock && !reset_datapath) begin
                    state_next = HUNT;
                end
            end
            HUNT: begin
                if (vld && any_match) begin
                    shift_next = hunt_shift;
                    cnt_next   = CW'(1);
                    state_next = CONFIRM;
                end
            end
            CONFIRM: begin
                if (vld) begin
                    if (match[shift_reg]) begin
                        // The HUNT hit counted as the first match.
                        if (cnt_reg >= CW'(CONFIRM_CNT - 1)) begin
                            state_next     = LOCKED;
                            status_next[1] = 1'b0;
                            cnt_next       = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end else begin
                        state_next = HUNT;
                        cnt_next   = '0;
                    end
                end
            end
            LOCKED: begin
                if (vld) begin
                    if (match[shift_reg]) begin
                        errcnt_next = '0;
                    end else if (errcnt_reg >= EW'(ERR_THR - 1)) begin
                        status_next[1] = 1'b1;
                        errcnt_next    = '0;
                        state_next     = HUNT;
                    end else begin
                        errcnt_next = errcnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (!lock) begin
            state_next    = IDLE;
            status_next   = 2'b11;
            cnt_next      = '0;
            errcnt_next   = '0;
            win_cnt_next  = '0;
            win_flag_next = 1'b0;
        end else if (reset_datapath) begin
            // status[0] is left as computed above so a window that ends on
            // this cycle still reports.
            state_next     = IDLE;
            shift_next     = '0;
            status_next[1] = 1'b1;
            cnt_next       = '0;
            errcnt_next    = '0;
            win_cnt_next   = '0;
            win_flag_next  = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: remember the last valid word and register the shifted word.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg     <= '0;
            data_out_reg <= '0;
            dov_reg      <= 1'b0;
        end else begin
            dov_reg <= vld;
            if (vld) begin
                prev_reg     <= rx_data;
                data_out_reg <= cand[shift_reg];
            end
        end
    end

`ifdef ALIGN_ERR_CNT_EN
    logic [15:0] err_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg <= '0;
        end else if (reset_datapath) begin
            err_count_reg <= '0;
        end else if (vld && state_reg == LOCKED && !match[shift_reg]
                     && err_count_reg != 16'hFFFF) begin
            err_count_reg <= err_count_reg + 16'd1;
        end
    end

    assign err_count = err_count_reg;
`endif

    assign align_status   = status_reg;
    assign data_out       = data_out_reg;
    assign data_out_valid = dov_reg;
    assign shift          = shift_reg;
    assign aligned        = (state_reg == LOCKED);

endmodule
